// File: rtl/display_scheduler_if.sv
// Bundles the alarm and keyboard requester inputs and the board display outputs
// of the display scheduler.
//
// Handshake: key_stb is a valid-only strobe with no ready back-pressure. It is
// high for exactly one clk, and key_digits is meaningful only while it is high.
// The scheduler samples both on that rising edge. It takes the request unless
// the alarm level is alerta. A refused strobe is simply dropped, so the sender
// must not hold or repeat it waiting for an acknowledgement.
interface display_scheduler_if;
    logic [15:0] alarm_digits;
    logic [1:0]  alarm_level;
    logic [15:0] key_digits;
    logic        key_stb;
    logic [3:0]  cualdisplay;
    logic [7:0]  display;
    logic        owner;
    logic        state_dbg;

    // Requesters and the bench drive the inputs and observe the outputs.
    modport master (
        output alarm_digits, alarm_level, key_digits, key_stb,
        input  cualdisplay, display, owner, state_dbg
    );

    // The scheduler consumes the requests and drives the display pins.
    modport slave (
        input  alarm_digits, alarm_level, key_digits, key_stb,
        output cualdisplay, display, owner, state_dbg
    );
endinterface

// File: rtl/display_scheduler.sv
// Time-shares the 4-digit 7-segment display between the alarm FSM and the
// keyboard echo. Keyboard echo holds the display for HOLD_CYCLES after its last
// strobe, alerta preempts it, and the digits blink while alerta is shown.
module display_scheduler #(
    parameter int SCAN_DIV    = 50000,
    parameter int HOLD_CYCLES = 100000000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic               clk,
    input  logic               rst,
    display_scheduler_if.slave bus
);
    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    typedef enum logic {
        ST_ALARM = 1'b0,
        ST_KEY   = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [15:0]          latch_q, latch_d;
    logic [SCAN_W-1:0]    scan_cnt;
    logic [1:0]           idx_q;
    logic [BLINK_W-1:0]   blink_cnt;
    logic                 phase_on_q;
    logic [3:0]           cual_scan_q;
    logic [7:0]           disp_q;
    logic                 alerta;
    logic                 blink_run;
    logic [15:0]          src_digits;
    logic [3:0]           nibble;

    // Level 11 is treated exactly like 10.
    assign alerta    = (bus.alarm_level == 2'b10) || (bus.alarm_level == 2'b11);
    assign blink_run = alerta && (state_q == ST_ALARM);

    // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Ownership arbitration: preemption by alerta beats a new strobe, and a
    // strobe beats hold expiry.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        latch_d = latch_q;
        case (state_q)
            ST_ALARM: begin
                if (bus.key_stb && !alerta) begin
                    state_d = ST_KEY;
                    hold_d  = HOLD_LAST;
                    latch_d = bus.key_digits;
                end
            end
            ST_KEY: begin
                if (alerta) begin
                    state_d = ST_ALARM;
                end else if (bus.key_stb) begin
                    hold_d  = HOLD_LAST;
                    latch_d = bus.key_digits;
                end else if (hold_q == '0) begin
                    state_d = ST_ALARM;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: state_d = ST_ALARM;
        endcase
    end

    // Arbitration state, hold timer and keyboard latch registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_ALARM;
            hold_q  <= '0;
            latch_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            latch_q <= latch_d;
        end
    end

    // Digit scan prescaler and digit index; it never stops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            idx_q    <= 2'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx_q    <= idx_q + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // Blink timer runs only while alerta is shown by the alarm side.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt  <= '0;
            phase_on_q <= 1'b1;
        end else if (!blink_run) begin
            blink_cnt  <= '0;
            phase_on_q <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt  <= '0;
            phase_on_q <= ~phase_on_q;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    // Pick the nibble for the current digit from whoever owns the display.
    always_comb begin
        src_digits = (state_q == ST_KEY) ? latch_q : bus.alarm_digits;
        nibble     = 4'h0;
        case (idx_q)
            2'd0: nibble = src_digits[3:0];
            2'd1: nibble = src_digits[7:4];
            2'd2: nibble = src_digits[11:8];
            2'd3: nibble = src_digits[15:12];
            default: nibble = 4'h0;
        endcase
    end

    // Registered digit enable and segments; dp marks digit 0 of keyboard echo.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cual_scan_q <= 4'b1111;
            disp_q      <= 8'hFF;
        end else begin
            cual_scan_q <= ~(4'b0001 << idx_q);
            disp_q      <= {~((state_q == ST_KEY) && (idx_q == 2'd0)), hex_to_seg(nibble)};
        end
    end

    // Blank phase gates the enables only; segment data keeps updating.
    assign bus.cualdisplay = phase_on_q ? cual_scan_q : 4'b1111;
    assign bus.display     = disp_q;
    assign bus.owner       = (state_q == ST_KEY);
    assign bus.state_dbg   = state_q;
endmodule
